lr_predict_sequencer: RTL and testbench
=======================================

# lr_predict_sequencer

Batch controller in front of the linear-regression prediction datapath. It latches the model parameters (theta0, theta1), buffers incoming x samples in a FIFO, and issues exactly `i_batch_len` samples to the datapath once theta is valid. It collects the in-order results and tags each with its index in the batch. Theta updates that arrive during a batch are deferred, so one batch never mixes two models.

## Interface
- `DATA_W`, 32, width of samples, theta and predictions
- `DEPTH`, 16, sample FIFO entries (power of two, ≥2)
- `i_clock` in 1: single clock, rising edge
- `i_reset` in 1: asynchronous, active-low reset
- `i_samples_x_in` in DATA_W: incoming x sample
- `i_samples_x_vld` in 1: sample valid; accepted when `o_samples_x_rdy`=1
- `o_samples_x_rdy` out 1: FIFO not full
- `i_theta0_in`, `i_theta1_in` in DATA_W: new model parameters
- `i_theta_vld` in 1: one-cycle strobe loading both theta inputs
- `i_start` in 1: batch start request
- `i_batch_len` in 8: samples in the batch, sampled with `i_start`
- `o_dp_x` out DATA_W: sample issued to the datapath
- `o_dp_x_vld` out 1: issue strobe
- `o_dp_theta0`, `o_dp_theta1` out DATA_W: active theta
- `o_dp_theta_vld` out 1: active theta is loaded
- `i_dp_predict` in DATA_W: datapath result
- `i_dp_predict_vld` in 1: result strobe; results return in issue order
- `o_predict_out` out DATA_W: registered result
- `o_predict_idx` out 8: index of the result within the batch (0-based)
- `o_predict_out_vld` out 1: result strobe
- `o_busy` out 1: state is RUN or DRAIN
- `o_done` out 1: one-cycle batch-complete pulse
- `o_drop_cnt` out 16: count of samples offered while the FIFO was full

## Operation
- **Reset values.** All outputs are 0 except `o_samples_x_rdy`=1. The FIFO is empty, the state is IDLE, theta and shadow theta are 0, and the pending flag is clear.
- **FSM.**
  - IDLE→READY on `i_theta_vld`.
  - READY→RUN on `i_start` with `i_batch_len`≠0.
  - `i_start` with `i_batch_len`=0 in READY pulses `o_done` on the next cycle and stays in READY.
  - RUN→DRAIN when the issued count reaches the batch length.
  - DRAIN→READY when the outstanding count is 0, with `o_done` pulsed.
  - `i_start` outside READY is ignored.
- **FIFO.**
  - Push when `i_samples_x_vld` and `o_samples_x_rdy` are both 1.
  - `o_samples_x_rdy` = !full. A pop in the same cycle does not raise it.
  - Pointers wrap modulo DEPTH. Samples may be pushed in any state.
- **Issue.** In RUN, pop one entry per cycle while the FIFO is not empty and issued < length. An empty FIFO stalls issue; there is no timeout.
- **Outstanding count.** +1 per issue, −1 per `i_dp_predict_vld`, both in the same cycle net 0. Results arriving while not in RUN/DRAIN are ignored.
- **Result tagging.** `o_predict_idx` = return counter, cleared on batch start and incremented per result.
- **Theta in IDLE/READY.** `i_theta_vld` loads the active theta directly.
- **Theta in RUN/DRAIN.**
  - `i_theta_vld` writes the shadow registers and sets the pending flag; the last strobe wins.
  - Shadow is copied to active on the cycle `o_done` is pulsed.
  - If `i_theta_vld` and the final return occur together, the new value goes to shadow and is then applied.
- **Theta valid.** `o_dp_theta_vld` = 1 in every state except IDLE.
- **Counters.** Issued, returned and outstanding counters are 8 bits; a batch is at most 255 samples.
- **Mid-batch reset.** Asserting `i_reset` aborts the batch, returns to IDLE, flushes the FIFO and loses theta.

## Timing
- **Issue latency.** Pop on edge N puts `o_dp_x`/`o_dp_x_vld` on N+1 (registered).
- **Result latency.** `i_dp_predict_vld` on cycle M gives `o_predict_out_vld` on M+1.
- **Done.** `o_done` coincides with the last `o_predict_out_vld` of the batch.
- **Back-to-back batches.** The FSM is in READY the cycle after `o_done`, so `i_start` is accepted then. This gives a 1-cycle minimum gap between batches.
- **Theta load.** Active theta is visible one cycle after `i_theta_vld` (IDLE/READY), or one cycle after `o_done` (deferred).
- **Throughput.** One sample per cycle.

## Configuration
- `LR_SEQ_DROP_CNT_EN`
  - **Defined:** `o_drop_cnt` increments on every cycle with `i_samples_x_vld`=1 and `o_samples_x_rdy`=0. It saturates at 0xFFFF and is cleared only by reset.
  - **Undefined:** `o_drop_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- **Single batch.** Reset, theta0=115313, theta1=2, push x=5,3,15, start with len=3. The datapath model returns theta0+theta1·x after 1 cycle. Require `o_predict_out` = 115323, 115319, 115343 with idx 0, 1, 2, then `o_done` with the last result.
- **FIFO full and drops.** Push 18 samples with no start. Require `o_samples_x_rdy`=0 after 16, and `o_drop_cnt`=2 when the macro is defined (0 when not). Start with len=16; require 16 results with idx 0..15.
- **Issue stall.** Start with len=4 and an empty FIFO. Require no `o_dp_x_vld`. Push one sample every 3 cycles; require exactly 4 issues, then `o_done`.
- **Deferred theta.** Load theta1=7 during RUN. Require `o_dp_theta1`=2 until `o_done`, then 7 on the next cycle. The next batch with x=1 returns 115320.
- **Boundary inputs.**
  - `i_start` with len=0: `o_done` on the next cycle, no issue.
  - `i_start` in IDLE: ignored.
  - Reset asserted mid-DRAIN: all outputs return to reset values, `o_samples_x_rdy`=1.

Source files
------------

// File: rtl/lr_predict_sequencer_if.sv
// Sample, theta, control and datapath signals of lr_predict_sequencer.
// master: the surrounding system and datapath; slave: the sequencer.
interface lr_predict_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] i_samples_x_in;
    logic              i_samples_x_vld;
    logic              o_samples_x_rdy;
    logic [DATA_W-1:0] i_theta0_in;
    logic [DATA_W-1:0] i_theta1_in;
    logic              i_theta_vld;
    logic              i_start;
    logic [7:0]        i_batch_len;
    logic [DATA_W-1:0] o_dp_x;
    logic              o_dp_x_vld;
    logic [DATA_W-1:0] o_dp_theta0;
    logic [DATA_W-1:0] o_dp_theta1;
    logic              o_dp_theta_vld;
    logic [DATA_W-1:0] i_dp_predict;
    logic              i_dp_predict_vld;
    logic [DATA_W-1:0] o_predict_out;
    logic [7:0]        o_predict_idx;
    logic              o_predict_out_vld;
    logic              o_busy;
    logic              o_done;
    logic [15:0]       o_drop_cnt;

    modport master (
        output i_samples_x_in, i_samples_x_vld, i_theta0_in, i_theta1_in, i_theta_vld,
               i_start, i_batch_len, i_dp_predict, i_dp_predict_vld,
        input  o_samples_x_rdy, o_dp_x, o_dp_x_vld, o_dp_theta0, o_dp_theta1, o_dp_theta_vld,
               o_predict_out, o_predict_idx, o_predict_out_vld, o_busy, o_done, o_drop_cnt
    );

    modport slave (
        input  i_samples_x_in, i_samples_x_vld, i_theta0_in, i_theta1_in, i_theta_vld,
               i_start, i_batch_len, i_dp_predict, i_dp_predict_vld,
        output o_samples_x_rdy, o_dp_x, o_dp_x_vld, o_dp_theta0, o_dp_theta1, o_dp_theta_vld,
               o_predict_out, o_predict_idx, o_predict_out_vld, o_busy, o_done, o_drop_cnt
    );
endinterface

// File: rtl/lr_predict_sequencer.sv
// Batch sequencer for the linear-regression datapath: sample FIFO, theta latch/deferral, result tagging.
// Optional: define LR_SEQ_DROP_CNT_EN to count samples offered while the FIFO is full.
module lr_predict_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic                 i_clock,
    input logic                 i_reset,
    lr_predict_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DRAIN} state_t;
    state_t state_reg, state_next;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic              fifo_full, fifo_empty, push, pop;

    logic [7:0]        len_reg, issued_reg, returned_reg, outstanding_reg, outstanding_next;
    logic [DATA_W-1:0] dp_x_reg, predict_out_reg;
    logic [7:0]        predict_idx_reg;
    logic              dp_x_vld_reg, predict_out_vld_reg, done_reg, pending_reg;
    logic              start_run, start_empty, ret, run_active;
    logic              done_next, theta_direct, busy, theta_vld;
    logic [1:0][DATA_W-1:0] theta_in;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign push        = bus.i_samples_x_vld && !fifo_full;
    assign run_active  = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign pop         = (state_reg == S_RUN) && !fifo_empty && (issued_reg < len_reg);
    assign ret         = bus.i_dp_predict_vld && run_active;
    assign start_run   = (state_reg == S_READY) && bus.i_start && (bus.i_batch_len != 8'd0);
    assign start_empty = bus.i_start && (bus.i_batch_len == 8'd0);
    assign outstanding_next = outstanding_reg + {7'd0, pop} - {7'd0, ret};
    assign theta_in    = {bus.i_theta1_in, bus.i_theta0_in};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.i_theta_vld) state_next = S_READY;
            S_READY: if (start_run) state_next = S_RUN;
            S_RUN:   if (pop && ((issued_reg + 8'd1) == len_reg)) state_next = S_DRAIN;
            S_DRAIN: if (outstanding_next == 8'd0) state_next = S_READY;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        done_next    = 1'b0;
        theta_direct = 1'b0;
        busy         = 1'b0;
        theta_vld    = 1'b0;
        case (state_reg)
            S_IDLE:  theta_direct = 1'b1;
            S_READY: begin
                theta_direct = 1'b1;
                theta_vld    = 1'b1;
                done_next    = start_empty;
            end
            S_RUN: begin
                busy      = 1'b1;
                theta_vld = 1'b1;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                theta_vld = 1'b1;
                done_next = (outstanding_next == 8'd0);
            end
            default: theta_direct = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.i_samples_x_in;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            dp_x_reg            <= '0;
            dp_x_vld_reg        <= 1'b0;
            len_reg             <= 8'd0;
            issued_reg          <= 8'd0;
            returned_reg        <= 8'd0;
            outstanding_reg     <= 8'd0;
            predict_out_reg     <= '0;
            predict_idx_reg     <= 8'd0;
            predict_out_vld_reg <= 1'b0;
            done_reg            <= 1'b0;
            pending_reg         <= 1'b0;
        end else begin
            done_reg        <= done_next;
            dp_x_vld_reg    <= pop;
            outstanding_reg <= outstanding_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
                dp_x_reg   <= fifo_mem[rd_ptr_reg[AW-1:0]];
            end
            if (start_run) begin
                len_reg      <= bus.i_batch_len;
                issued_reg   <= 8'd0;
                returned_reg <= 8'd0;
            end else begin
                if (pop) issued_reg   <= issued_reg + 8'd1;
                if (ret) returned_reg <= returned_reg + 8'd1;
            end
            predict_out_vld_reg <= ret;
            if (ret) begin
                predict_out_reg <= bus.i_dp_predict;
                predict_idx_reg <= returned_reg;
            end
            // A strobe during a batch parks in shadow; any strobe outside a batch supersedes it.
            if (bus.i_theta_vld && !theta_direct) pending_reg <= 1'b1;
            else if (bus.i_theta_vld || done_reg) pending_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_theta
            logic [DATA_W-1:0] active_reg, shadow_reg;
            always_ff @(posedge i_clock or negedge i_reset) begin
                if (!i_reset) begin
                    active_reg <= '0;
                    shadow_reg <= '0;
                end else begin
                    if (bus.i_theta_vld && theta_direct) active_reg <= theta_in[gi];
                    else if (done_reg && pending_reg)    active_reg <= shadow_reg;
                    if (bus.i_theta_vld && !theta_direct) shadow_reg <= theta_in[gi];
                end
            end
        end
    endgenerate

`ifdef LR_SEQ_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) drop_cnt_reg <= 16'd0;
        else if (bus.i_samples_x_vld && fifo_full && (drop_cnt_reg != 16'hFFFF))
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
    assign bus.o_drop_cnt = drop_cnt_reg;
`else
    assign bus.o_drop_cnt = 16'd0;
`endif

    assign bus.o_samples_x_rdy   = !fifo_full;
    assign bus.o_dp_x            = dp_x_reg;
    assign bus.o_dp_x_vld        = dp_x_vld_reg;
    assign bus.o_dp_theta0       = g_theta[0].active_reg;
    assign bus.o_dp_theta1       = g_theta[1].active_reg;
    assign bus.o_dp_theta_vld    = theta_vld;
    assign bus.o_predict_out     = predict_out_reg;
    assign bus.o_predict_idx     = predict_idx_reg;
    assign bus.o_predict_out_vld = predict_out_vld_reg;
    assign bus.o_busy            = busy;
    assign bus.o_done            = done_reg;
endmodule

// File: tb/tb_lr_predict_sequencer.sv
// Randomized self-checking bench for lr_predict_sequencer against a queue-based batch model.
module tb_lr_predict_sequencer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lr_predict_sequencer_if #(.DATA_W(DATA_W)) dut_if ();

    lr_predict_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (dut_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] sw_fifo [$];
    logic [31:0] exp_val [$];
    int          exp_idx [$];
    logic [31:0] m_t0 = 0, m_t1 = 0, m_s0 = 0, m_s1 = 0;
    bit          m_pend = 0, m_ready = 0, m_busy = 0;
    int          m_idx = 0, m_len = 0, drop_exp = 0;
    int          issue_cnt = 0, res_cnt = 0, done_cnt = 0;
    logic [31:0] last_res = 0;
    logic [31:0] mon_x;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sw_fifo.delete();
        exp_val.delete();
        exp_idx.delete();
        m_t0 = 0; m_t1 = 0; m_s0 = 0; m_s1 = 0;
        m_pend = 0; m_ready = 0; m_busy = 0;
        m_idx = 0; m_len = 0; drop_exp = 0;
    endtask

    task automatic push_x(input logic [31:0] x);
        dut_if.i_samples_x_in  = x;
        dut_if.i_samples_x_vld = 1'b1;
        if (sw_fifo.size() < DEPTH) sw_fifo.push_back(x);
        else                        drop_exp++;
        step();
        dut_if.i_samples_x_vld = 1'b0;
    endtask

    task automatic start_batch(input int len);
        dut_if.i_start     = 1'b1;
        dut_if.i_batch_len = 8'(len);
        if (m_ready && !m_busy) begin
            m_len = len;
            m_idx = 0;
            if (len != 0) m_busy = 1;
        end
        step();
        dut_if.i_start = 1'b0;
    endtask

    task automatic theta_load(input logic [31:0] t0, input logic [31:0] t1);
        dut_if.i_theta0_in = t0;
        dut_if.i_theta1_in = t1;
        dut_if.i_theta_vld = 1'b1;
        if (m_busy) begin
            m_s0 = t0; m_s1 = t1; m_pend = 1;
        end else begin
            m_t0 = t0; m_t1 = t1; m_ready = 1;
        end
        step();
        dut_if.i_theta_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = done_cnt;
        int i = 0;
        while (done_cnt == base && i < budget) begin
            step();
            i++;
        end
        check_eq(tag, 32'(done_cnt - base), 1);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_rdy"},       32'(dut_if.o_samples_x_rdy), 1);
        check_eq({tag, "_busy"},      32'(dut_if.o_busy), 0);
        check_eq({tag, "_done"},      32'(dut_if.o_done), 0);
        check_eq({tag, "_dp_x_vld"},  32'(dut_if.o_dp_x_vld), 0);
        check_eq({tag, "_dp_x"},      dut_if.o_dp_x, 0);
        check_eq({tag, "_theta_vld"}, 32'(dut_if.o_dp_theta_vld), 0);
        check_eq({tag, "_theta0"},    dut_if.o_dp_theta0, 0);
        check_eq({tag, "_theta1"},    dut_if.o_dp_theta1, 0);
        check_eq({tag, "_pred_vld"},  32'(dut_if.o_predict_out_vld), 0);
        check_eq({tag, "_pred"},      dut_if.o_predict_out, 0);
        check_eq({tag, "_idx"},       32'(dut_if.o_predict_idx), 0);
        check_eq({tag, "_drop"},      32'(dut_if.o_drop_cnt), 0);
    endtask

    // Datapath model: result = theta0 + theta1*x, one cycle after the issue is seen.
    initial begin
        logic        rsp_vld;
        logic [31:0] rsp_val;
        dut_if.i_dp_predict_vld = 1'b0;
        dut_if.i_dp_predict     = '0;
        forever begin
            @(negedge clk);
            rsp_vld = dut_if.o_dp_x_vld;
            rsp_val = dut_if.o_dp_theta0 + dut_if.o_dp_theta1 * dut_if.o_dp_x;
            @(posedge clk);
            #1;
            dut_if.i_dp_predict_vld = rsp_vld;
            dut_if.i_dp_predict     = rsp_val;
        end
    end

    // Scoreboard: results, batch completion, then issues (an issue never matches a same-cycle result).
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut_if.o_predict_out_vld) begin
                res_cnt++;
                last_res = dut_if.o_predict_out;
                if (exp_val.size() == 0) begin
                    check_eq("result_unexpected", 32'(dut_if.o_predict_out_vld), 0);
                end else begin
                    check_eq("result_value", dut_if.o_predict_out, exp_val.pop_front());
                    check_eq("result_idx", 32'(dut_if.o_predict_idx), 32'(exp_idx.pop_front()));
                end
            end
            if (dut_if.o_done) begin
                done_cnt++;
                check_eq("done_with_last", 32'(dut_if.o_predict_out_vld), (m_len != 0) ? 1 : 0);
                check_eq("done_all_returned", 32'(exp_val.size()), 0);
                if (m_pend) begin
                    m_t0 = m_s0; m_t1 = m_s1; m_pend = 0;
                end
                m_busy = 0;
            end
            if (dut_if.o_dp_x_vld) begin
                issue_cnt++;
                if (sw_fifo.size() == 0) begin
                    check_eq("issue_unexpected", 32'(dut_if.o_dp_x_vld), 0);
                end else begin
                    mon_x = sw_fifo.pop_front();
                    check_eq("issue_x", dut_if.o_dp_x, mon_x);
                    exp_val.push_back(m_t0 + m_t1 * mon_x);
                    exp_idx.push_back(m_idx);
                    m_idx++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, r0, d0, len, n;
        dut_if.i_samples_x_in  = '0;
        dut_if.i_samples_x_vld = 1'b0;
        dut_if.i_theta0_in     = '0;
        dut_if.i_theta1_in     = '0;
        dut_if.i_theta_vld     = 1'b0;
        dut_if.i_start         = 1'b0;
        dut_if.i_batch_len     = 8'd0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        step();

        // Start in IDLE is ignored
        d0 = done_cnt;
        start_batch(3);
        repeat (4) step();
        check_eq("idle_start_busy", 32'(dut_if.o_busy), 0);
        check_eq("idle_start_done", 32'(done_cnt - d0), 0);
        check_eq("idle_theta_vld", 32'(dut_if.o_dp_theta_vld), 0);

        theta_load(32'd115313, 32'd2);
        check_eq("theta0_load", dut_if.o_dp_theta0, 32'd115313);
        check_eq("theta1_load", dut_if.o_dp_theta1, 32'd2);
        check_eq("theta_vld_ready", 32'(dut_if.o_dp_theta_vld), 1);

        // Single batch
        r0 = res_cnt;
        push_x(32'd5); push_x(32'd3); push_x(32'd15);
        start_batch(3);
        wait_done("single_done", 40);
        check_eq("single_results", 32'(res_cnt - r0), 3);
        check_eq("single_last", last_res, 32'd115343);

        // Zero-length start
        i0 = issue_cnt; d0 = done_cnt;
        start_batch(0);
        check_eq("len0_done_next", 32'(dut_if.o_done), 1);
        check_eq("len0_busy", 32'(dut_if.o_busy), 0);
        step();
        check_eq("len0_done_once", 32'(done_cnt - d0), 1);
        check_eq("len0_pulse", 32'(dut_if.o_done), 0);
        check_eq("len0_no_issue", 32'(issue_cnt - i0), 0);

        // FIFO full and drops
        for (int i = 0; i < 18; i++) begin
            if (i == 15) check_eq("rdy_before_full", 32'(dut_if.o_samples_x_rdy), 1);
            if (i == 16) check_eq("rdy_full", 32'(dut_if.o_samples_x_rdy), 0);
            push_x($urandom);
        end
`ifdef LR_SEQ_DROP_CNT_EN
        check_eq("drop_cnt", 32'(dut_if.o_drop_cnt), 32'(drop_exp));
`else
        check_eq("drop_cnt", 32'(dut_if.o_drop_cnt), 0);
`endif
        r0 = res_cnt;
        start_batch(16);
        wait_done("full_done", 80);
        check_eq("full_results", 32'(res_cnt - r0), 16);
        check_eq("full_rdy_after", 32'(dut_if.o_samples_x_rdy), 1);

        // Issue stall on empty FIFO
        i0 = issue_cnt;
        start_batch(4);
        repeat (6) step();
        check_eq("stall_no_issue", 32'(issue_cnt - i0), 0);
        check_eq("stall_busy", 32'(dut_if.o_busy), 1);
        for (int k = 0; k < 4; k++) begin
            push_x($urandom);
            step();
            step();
        end
        wait_done("stall_done", 40);
        check_eq("stall_issues", 32'(issue_cnt - i0), 4);

        // Randomized batches
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                theta_load($urandom, $urandom);
                check_eq("rand_theta0", dut_if.o_dp_theta0, m_t0);
                check_eq("rand_theta1", dut_if.o_dp_theta1, m_t1);
            end
            len = int'($urandom_range(1, 12));
            i0 = issue_cnt; r0 = res_cnt;
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < len; k++) push_x($urandom);
                start_batch(len);
            end else begin
                start_batch(len);
                for (int k = 0; k < len; k++) push_x($urandom);
            end
            wait_done("rand_done", 100);
            check_eq("rand_issues", 32'(issue_cnt - i0), 32'(len));
            check_eq("rand_results", 32'(res_cnt - r0), 32'(len));
        end

        // Deferred theta update
        theta_load(32'd115313, 32'd2);
        start_batch(2);
        repeat (3) step();
        theta_load(32'd115313, 32'd7);
        check_eq("defer_hold", dut_if.o_dp_theta1, 32'd2);
        push_x($urandom);
        push_x($urandom);
        n = 0;
        while (!dut_if.o_done && n < 40) begin
            step();
            n++;
        end
        check_eq("defer_done_seen", 32'(dut_if.o_done), 1);
        check_eq("defer_at_done", dut_if.o_dp_theta1, 32'd2);
        step();
        check_eq("defer_applied", dut_if.o_dp_theta1, 32'd7);
        push_x(32'd1);
        start_batch(1);
        wait_done("defer_next_done", 40);
        check_eq("defer_next_pred", last_res, 32'd115320);

        // Reset in the middle of DRAIN
        for (int k = 0; k < 5; k++) push_x($urandom);
        i0 = issue_cnt;
        start_batch(3);
        n = 0;
        while (issue_cnt < i0 + 3 && n < 40) begin
            step();
            n++;
        end
        check_eq("drain_reached", 32'(issue_cnt - i0), 3);
        check_eq("drain_busy", 32'(dut_if.o_busy), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset("rst_drain");
        step();
        step();
        check_reset("rst_hold");
        rst_n = 1'b1;
        step();

        // Leftover samples must have been flushed
        i0 = issue_cnt;
        theta_load(32'd115313, 32'd2);
        start_batch(1);
        repeat (6) step();
        check_eq("flush_no_issue", 32'(issue_cnt - i0), 0);
        check_eq("flush_busy", 32'(dut_if.o_busy), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
